// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: direction encodings, FSM states and
// the shift-amount width helper.
package shift_pkg;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  function automatic int SHAMT_W(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/logical_shift_core.sv
// Combinational zero-fill logical shifter; bits shifted past either end are lost.
module logical_shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]          data,
  input  logic [SHAMT_W(WIDTH)-1:0] shamt,
  input  logic                      dir,
  output logic [WIDTH-1:0]          result
);

  always_comb begin
    result = (dir == DIR_LEFT) ? (data << shamt) : (data >> shamt);
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one logical shifter between two requesters, with a
// registered result held until its owner accepts it.
//
// state  | meaning
// S_IDLE | no result held, any winning request is accepted
// S_HOLD | result registered in rsp_data_q for own_q, waiting for rsp_ready[own_q]
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [WIDTH-1:0]          req_data0,
  input  logic [WIDTH-1:0]          req_data1,
  input  logic [SHAMT_W(WIDTH)-1:0] req_shamt0,
  input  logic [SHAMT_W(WIDTH)-1:0] req_shamt1,
  input  logic                      req_dir0,
  input  logic                      req_dir1,
  output logic [1:0]                rsp_valid,
  input  logic [1:0]                rsp_ready,
  output logic [WIDTH-1:0]          rsp_data
);

  localparam int SW = SHAMT_W(WIDTH);

  state_t           state_q, state_d;
  logic             prio_q;
  logic             own_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             grant;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] mux_data;
  logic [SW-1:0]    mux_shamt;
  logic             mux_dir;
  logic [WIDTH-1:0] shift_res;

  always_comb begin
    grant = 1'b0;
    if (req_valid[0] && req_valid[1]) grant = prio_q;
    else if (req_valid[1])            grant = 1'b1;
  end

  always_comb begin
    mux_data  = grant ? req_data1  : req_data0;
    mux_shamt = grant ? req_shamt1 : req_shamt0;
    mux_dir   = grant ? req_dir1   : req_dir0;
  end

  logical_shift_core #(.WIDTH(WIDTH)) u_core (
    .data   (mux_data),
    .shamt  (mux_shamt),
    .dir    (mux_dir),
    .result (shift_res)
  );

  // In HOLD the owner's rsp_valid is always high, so only its rsp_ready matters.
  always_comb begin
    can_accept = (state_q == S_IDLE) || rsp_ready[own_q];
    req_ready  = 2'b00;
    if (!rst && can_accept) req_ready[grant] = req_valid[grant];
    accept = |req_ready;
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == S_HOLD) rsp_valid[own_q] = 1'b1;
    rsp_data = rsp_data_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_HOLD;
      S_HOLD:  if (rsp_ready[own_q]) state_d = accept ? S_HOLD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= 1'b0;
      own_q      <= 1'b0;
      rsp_data_q <= '0;
    end else if (accept) begin
      prio_q     <= ~grant;
      own_q      <= grant;
      rsp_data_q <= shift_res;
    end
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 32-bit logical shifter between two requesters (req 0: ALU shift path, req 1: address/branch unit) with round-robin arbitration, valid/ready handshakes on both the request and response sides, and a registered result. It sits between the decode/execute control and the shifter datapath, so the datapath is instantiated once and sequenced one operation at a time.

## Interface
Parameters:
- `WIDTH`, default 32: data width. Shift amount width is `$clog2(WIDTH)` (5 at default).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid[1:0]`  in  2: request pending, one bit per requester.
- `req_ready[1:0]`  out  2: request accepted this cycle when `req_valid[i] & req_ready[i]`.
- `req_data0`, `req_data1`  in  WIDTH each: operand per requester.
- `req_shamt0`, `req_shamt1`  in  5 each: shift amount per requester.
- `req_dir0`, `req_dir1`  in  1 each: 1 = left shift, 0 = right shift.
- `rsp_valid[1:0]`  out  2: result valid for requester i. At most one bit is set.
- `rsp_ready[1:0]`  in  2: requester i accepts the result.
- `rsp_data`  out  WIDTH: shared result bus; meaningful only while some `rsp_valid` bit is high.

## Operation
State machine, 2 states:
- IDLE: no result held.
- HOLD: result registered, waiting for the owner's `rsp_ready`.

Arbitration:
- Round-robin with a 1-bit priority pointer `prio`. Reset value 0, meaning requester 0 wins a tie.
- Only one requester valid: it wins.
- Both valid: `prio` wins.
- On every accepted request from requester i, `prio` <= ~i.
- A non-granted requester's `req_ready` is 0.

Accept condition:
- `req_ready[g] = req_valid[g] & (state==IDLE | rsp_valid[own] & rsp_ready[own])`, where g is the grant winner and `own` is the current result owner.
- This gives back-to-back throughput of 1 operation per cycle when responses are accepted immediately.

Datapath:
- `result = dir ? data << shamt : data >> shamt`, zero fill, shifted-out bits discarded.
- shamt 0 passes the operand through.
- The result is captured into `rsp_data_q` and the owner index into `own_q` on accept.

Transitions:
- IDLE --accept--> HOLD.
- HOLD --rsp handshake, no new accept--> IDLE.
- HOLD --rsp handshake and new accept in the same cycle--> HOLD, with the new data and owner.
- HOLD with no `rsp_ready[own]`: stays in HOLD. `rsp_data` and `rsp_valid` stay stable and no request is accepted.

Boundary conditions:
- `rsp_ready` from the non-owner is ignored.
- `req_valid` deasserting before accept is legal; nothing is recorded.
- Reset mid-operation: held result is discarded; no response is issued for it.

## Timing
- Reset values:
  - `state`=IDLE.
  - `rsp_valid`=2'b00.
  - `rsp_data`=0.
  - `req_ready`=2'b00 while `rst` is high.
  - `prio`=0.
  - `own_q`=0.
- Latency: request accepted at edge N gives `rsp_valid[i]`=1 with the result after edge N (visible in cycle N+1).
- `req_ready` is combinational from `req_valid`, `rsp_ready`, `state` and `prio`. There is no combinational path from `req_data`/`req_shamt` to any output.
- Sustained rate: 1 op/cycle with `rsp_ready` held high; alternates owners when both requesters stay valid.

## Structure
- Shared package `shift_pkg`:
  - `DIR_LEFT`=1'b1, `DIR_RIGHT`=1'b0.
  - State enum `{S_IDLE, S_HOLD}`.
  - `SHAMT_W` function.
- One sub-module: `logical_shift_core` (WIDTH, data, shamt, dir -> result), purely combinational. It is instantiated once and fed from a grant-selected mux.

## Test plan
- Reset mid-HOLD:
  - Stimulus: assert `rst` while HOLD.
  - Required: `rsp_valid`=00 and `rsp_data`=0 immediately (asynchronous); after release, a tie is granted to req 0.
- Single request:
  - Stimulus: req0 valid, data=0x8000_0001, shamt=1, dir=1, `rsp_ready0`=1.
  - Required: accepted in cycle 0; `rsp_valid`=01 with `rsp_data`=0x0000_0002 in cycle 1.
- Right shift and pass-through:
  - Stimulus: req1, data=0xF000_0000, shamt=31, dir=0.
  - Required: result 0x0000_0001.
  - Stimulus: shamt=0, dir=0.
  - Required: result 0xF000_0000.
- Contention:
  - Stimulus: both requesters valid continuously for 4 cycles with `rsp_ready`=11.
  - Required: grants in the order 0,1,0,1; one `rsp_valid` bit per cycle, each lagging its grant by one cycle.
- Backpressure:
  - Stimulus: req0 accepted, `rsp_ready0`=0 for 3 cycles, req1 valid throughout.
  - Required: `rsp_valid`=01 and `rsp_data` stable for 3 cycles; `req_ready`=00.
  - Stimulus: raise `rsp_ready0`.
  - Required: req1 accepted in that same cycle; `rsp_valid`=10 the next cycle.
- Wrong owner:
  - Stimulus: in HOLD owned by req1, assert `rsp_ready0`.
  - Required: no state change.
